// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_stage_pkg;

   localparam int unsigned INST_ADDR_W = 32;
   localparam int unsigned INST_W      = 32;
   localparam int unsigned STALL_W     = 6;

   localparam logic [INST_W-1:0]      ZERO_WORD    = '0;
   localparam logic [INST_ADDR_W-1:0] ZERO_ADDR    = '0;
   localparam logic                   RST_ENABLE   = 1'b1;
   localparam logic                   CHIP_ENABLE  = 1'b1;
   localparam logic                   CHIP_DISABLE = 1'b0;
   localparam logic                   STOP         = 1'b1;
   localparam logic                   NO_STOP      = 1'b0;

   // Stall vector bit positions
   localparam int unsigned STALL_PC = 0;
   localparam int unsigned STALL_IF = 1;
   localparam int unsigned STALL_ID = 2;

   // Fetch enable: off while in reset, on from the first edge after release
   typedef enum logic {
      FETCH_OFF = 1'b0,
      FETCH_ON  = 1'b1
   } fetch_state_t;

endpackage : if_stage_pkg

// File: rtl/if_stage_if.sv
// Instruction ROM bus: fetch address and chip enable out, instruction back.
interface if_stage_if;
   import if_stage_pkg::*;

   logic [INST_ADDR_W-1:0] pc_o;
   logic                   ce_o;
   logic [INST_W-1:0]      rom_inst_i;

   // Fetch stage side
   modport master (
      output pc_o,
      output ce_o,
      input  rom_inst_i
   );

   // ROM side
   modport slave (
      input  pc_o,
      input  ce_o,
      output rom_inst_i
   );

endinterface : if_stage_if

// File: rtl/if_stage_if_id.sv
// IF/ID pipeline register with flush, bubble and hold rules.
module if_stage_if_id
   import if_stage_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic [STALL_W-1:0]     stall,
   input  logic [INST_ADDR_W-1:0] if_pc,
   input  logic [INST_W-1:0]      if_inst,
   output logic [INST_ADDR_W-1:0] id_pc,
   output logic [INST_W-1:0]      id_inst
);

   logic unused_stall;
   assign unused_stall = ^{stall[STALL_W-1:STALL_ID+1], stall[STALL_PC]};

   // Capture fetched instruction; bubble when IF stalls but ID runs; hold when both stall
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE || flush) begin
         id_pc   <= ZERO_ADDR;
         id_inst <= ZERO_WORD;
      end else if (stall[STALL_IF] == STOP && stall[STALL_ID] == NO_STOP) begin
         id_pc   <= ZERO_ADDR;
         id_inst <= ZERO_WORD;
      end else if (stall[STALL_IF] == NO_STOP) begin
         id_pc   <= if_pc;
         id_inst <= if_inst;
      end
   end

endmodule : if_stage_if_id

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, ROM enable and IF/ID register.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000,
   parameter logic [INST_ADDR_W-1:0] PC_INC   = 32'd4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [STALL_W-1:0]     stall,
   input  logic                   flush,
   input  logic [INST_ADDR_W-1:0] new_pc,
   input  logic                   branch_flag_i,
   input  logic [INST_ADDR_W-1:0] branch_target_address_i,
   if_stage_if.master             rom_bus,
   output logic [INST_ADDR_W-1:0] id_pc_o,
   output logic [INST_W-1:0]      id_inst_o
);

   fetch_state_t           state, state_next;
   logic                   ce;
   logic [INST_ADDR_W-1:0] pc;
   logic [INST_W-1:0]      if_inst;

   // Fetch-enable state register
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) state <= FETCH_OFF;
      else                   state <= state_next;
   end

   // Next fetch state and chip enable decode
   always_comb begin
      state_next = state;
      ce         = CHIP_DISABLE;
      unique case (state)
         FETCH_OFF: state_next = FETCH_ON;
         FETCH_ON:  ce         = CHIP_ENABLE;
         default:   state_next = FETCH_OFF;
      endcase
   end

   // PC update: reset/disabled, flush, stall, branch, sequential (wraps modulo 2^32)
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE)           pc <= RESET_PC;
      else if (ce == CHIP_DISABLE)     pc <= RESET_PC;
      else if (flush)                  pc <= new_pc;
      else if (stall[STALL_PC] == STOP) pc <= pc;
      else if (branch_flag_i)          pc <= branch_target_address_i;
      else                             pc <= pc + PC_INC;
   end

   assign rom_bus.pc_o = pc;
   assign rom_bus.ce_o = ce;
   assign if_inst      = (ce == CHIP_ENABLE) ? rom_bus.rom_inst_i : ZERO_WORD;

   if_stage_if_id u_if_id (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .stall   (stall),
      .if_pc   (pc),
      .if_inst (if_inst),
      .id_pc   (id_pc_o),
      .id_inst (id_inst_o)
   );

endmodule : if_stage

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a behavioural instruction ROM.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        branch_flag_i;
   logic [31:0] branch_target_address_i;
   logic [31:0] id_pc_o;
   logic [31:0] id_inst_o;

   int unsigned errors = 0;
   int unsigned checks = 0;

   if_stage_if rom_bus ();

   // ROM contents: a recognisable word derived from the address
   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return 32'hA5C3_0000 ^ {a[15:0], a[31:16]};
   endfunction

   assign rom_bus.rom_inst_i = rom_word(rom_bus.pc_o);

   if_stage #(
      .RESET_PC (32'h0000_0000),
      .PC_INC   (32'd4)
   ) dut (
      .clk                     (clk),
      .rst                     (rst),
      .stall                   (stall),
      .flush                   (flush),
      .new_pc                  (new_pc),
      .branch_flag_i           (branch_flag_i),
      .branch_target_address_i (branch_target_address_i),
      .rom_bus                 (rom_bus.master),
      .id_pc_o                 (id_pc_o),
      .id_inst_o               (id_inst_o)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Compare all four outputs after an edge
   task automatic expect_all(input string tag, input logic ce, input logic [31:0] pc,
                             input logic [31:0] ipc, input logic [31:0] iinst);
      check_eq({tag, ".ce"},      {31'd0, rom_bus.ce_o}, {31'd0, ce});
      check_eq({tag, ".pc"},      rom_bus.pc_o, pc);
      check_eq({tag, ".id_pc"},   id_pc_o, ipc);
      check_eq({tag, ".id_inst"}, id_inst_o, iinst);
   endtask

   initial begin
      rst = 1'b1; stall = '0; flush = 1'b0; new_pc = '0;
      branch_flag_i = 1'b0; branch_target_address_i = '0;

      // Reset for three cycles
      for (int i = 0; i < 3; i++) begin
         step();
         expect_all("reset", 1'b0, 32'h0, 32'h0, 32'h0);
      end

      // Release: first edge enables ROM with pc at RESET_PC
      rst = 1'b0;
      step(); expect_all("start",  1'b1, 32'h0,  32'h0, 32'h0);
      step(); expect_all("seq4",   1'b1, 32'h4,  32'h0, rom_word(32'h0));
      step(); expect_all("seq8",   1'b1, 32'h8,  32'h4, rom_word(32'h4));
      step(); expect_all("seq12",  1'b1, 32'hC,  32'h8, rom_word(32'h8));
      step(); expect_all("seq16",  1'b1, 32'h10, 32'hC, rom_word(32'hC));

      // Stall PC and IF with ID running: PC holds, bubbles to ID
      stall = 6'b000011;
      step(); expect_all("stall1", 1'b1, 32'h10, 32'h0, 32'h0);
      step(); expect_all("stall2", 1'b1, 32'h10, 32'h0, 32'h0);
      stall = '0;
      step(); expect_all("resume", 1'b1, 32'h14, 32'h10, rom_word(32'h10));
      step(); step(); step();
      expect_all("to20",   1'b1, 32'h20, 32'h1C, rom_word(32'h1C));

      // Taken branch at 0x20: delay slot still reaches ID
      branch_flag_i = 1'b1; branch_target_address_i = 32'h100;
      step(); expect_all("branch", 1'b1, 32'h100, 32'h20, rom_word(32'h20));
      branch_flag_i = 1'b0;
      step(); expect_all("target", 1'b1, 32'h104, 32'h100, rom_word(32'h100));

      // IF and ID both stalled: IF/ID register holds
      stall = 6'b000111;
      step(); expect_all("hold",   1'b1, 32'h104, 32'h100, rom_word(32'h100));
      stall = '0;
      step(); expect_all("unhold", 1'b1, 32'h108, 32'h104, rom_word(32'h104));

      // PC stall ignores a branch presented in the same cycle
      stall = 6'b000001; branch_flag_i = 1'b1; branch_target_address_i = 32'h200;
      step(); expect_all("stallbr", 1'b1, 32'h108, 32'h108, rom_word(32'h108));

      // Flush beats stall and branch
      flush = 1'b1; new_pc = 32'h180; stall = 6'b000011;
      step(); expect_all("flush",  1'b1, 32'h180, 32'h0, 32'h0);
      flush = 1'b0; stall = '0; branch_flag_i = 1'b0;
      step(); expect_all("postfl", 1'b1, 32'h184, 32'h180, rom_word(32'h180));

      // Wrap at the top of the address space
      flush = 1'b1; new_pc = 32'hFFFF_FFFC;
      step(); expect_all("wrapset", 1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0);
      flush = 1'b0;
      step(); expect_all("wrap0",  1'b1, 32'h0, 32'hFFFF_FFFC, rom_word(32'hFFFF_FFFC));
      step(); expect_all("wrap4",  1'b1, 32'h4, 32'h0, rom_word(32'h0));

      // Reset while a branch is pending
      branch_flag_i = 1'b1; branch_target_address_i = 32'h300; rst = 1'b1;
      step(); expect_all("midrst", 1'b0, 32'h0, 32'h0, 32'h0);
      rst = 1'b0; branch_flag_i = 1'b0;
      step(); expect_all("restart", 1'b1, 32'h0, 32'h0, 32'h0);
      step(); expect_all("reseq",  1'b1, 32'h4, 32'h0, rom_word(32'h0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Absolute time limit so the run always ends
   initial begin
      #100000;
      errors++;
      $display("FAIL timeout: got running expected finished");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_if_stage
